// File: rtl/uart_cmd_ctrl_if.sv
// Received-byte stream from the RS-232 receiver into the command controller.
//   rx_data_i  : received byte, meaningful only while rx_valid_i is high
//   rx_valid_i : one-cycle end-of-reception strobe per byte
// Handshake: a byte transfers on every rising clk edge where rx_valid_i = 1.
// There is no ready signal; the consumer must take every strobed byte.
// master = receiver side (drives), slave = controller side (samples).
interface uart_cmd_ctrl_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;

  modport master (output rx_data_i, output rx_valid_i);
  modport slave  (input  rx_data_i, input  rx_valid_i);
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller: parses 4-byte write frames (A5, ADDR, DATA, CHK)
// from the received byte stream and commits DATA into a 4 x 8-bit register
// file. Bad checksum, out-of-range address and inter-byte stalls are rejected
// with a one-cycle error strobe and a held error code.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   rx           : received byte stream (uart_cmd_ctrl_if.slave)
//   regs_o       : register file, reg k at [8k+7:8k]
//   wr_o         : one-cycle strobe, a register was written
//   wr_addr_o    : index of last written register (held)
//   err_o        : one-cycle strobe, frame rejected
//   err_code_o   : 1 checksum, 2 bad address, 3 timeout (held)
//   busy_o       : frame in progress
//   state_o      : current parser state, for observation
module uart_cmd_ctrl #(
  parameter int          TIMEOUT  = 1_000_000,
  parameter logic [31:0] REG_INIT = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  uart_cmd_ctrl_if.slave    rx,
  output logic [31:0]       regs_o,
  output logic              wr_o,
  output logic [1:0]        wr_addr_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic              busy_o,
  output logic [1:0]        state_o
);

  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GET_ADDR = 2'd1;
  localparam logic [1:0] GET_DATA = 2'd2;
  localparam logic [1:0] GET_CHK  = 2'd3;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_ADDR = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [7:0]    addr;
  logic [7:0]    data;

  assign state_o = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      addr       <= '0;
      data       <= '0;
      regs_o     <= REG_INIT;
      wr_o       <= 1'b0;
      wr_addr_o  <= 2'd0;
      err_o      <= 1'b0;
      err_code_o <= 2'd0;
      busy_o     <= 1'b0;
    end else begin
      wr_o  <= 1'b0;
      err_o <= 1'b0;
      if (rx.rx_valid_i) begin
        // A byte always wins over expiry: it is consumed and the counter reloads.
        cnt <= '0;
        case (state)
          IDLE: begin
            if (rx.rx_data_i == SYNC) begin
              state  <= GET_ADDR;
              busy_o <= 1'b1;
            end
          end
          GET_ADDR: begin
            addr  <= rx.rx_data_i;
            state <= GET_DATA;
          end
          GET_DATA: begin
            data  <= rx.rx_data_i;
            state <= GET_CHK;
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
            // Checksum takes priority over the address range check.
            if (rx.rx_data_i != (addr ^ data)) begin
              err_o      <= 1'b1;
              err_code_o <= ERR_CHK;
            end else if (addr > 8'd3) begin
              err_o      <= 1'b1;
              err_code_o <= ERR_ADDR;
            end else begin
              regs_o[{addr[1:0], 3'b000} +: 8] <= data;
              wr_o      <= 1'b1;
              wr_addr_o <= addr[1:0];
            end
          end
        endcase
      end else if (state != IDLE) begin
        // Counter never passes TIMEOUT-1: expiry forces IDLE and clears it.
        if (cnt == CW'(TIMEOUT - 1)) begin
          state      <= IDLE;
          busy_o     <= 1'b0;
          cnt        <= '0;
          err_o      <= 1'b1;
          err_code_o <= ERR_TMO;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_ctrl_if rx_bus ();

  logic [31:0] regs;
  logic        wr;
  logic [1:0]  wr_addr;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;
  logic [1:0]  state;

  uart_cmd_ctrl #(
    .TIMEOUT  (16),
    .REG_INIT (32'h4433_2211)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx         (rx_bus.slave),
    .regs_o     (regs),
    .wr_o       (wr),
    .wr_addr_o  (wr_addr),
    .err_o      (err),
    .err_code_o (err_code),
    .busy_o     (busy),
    .state_o    (state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive a byte for one cycle; returns #1 after the edge that consumed it.
  task automatic send(input logic [7:0] b);
    rx_bus.rx_data_i  = b;
    rx_bus.rx_valid_i = 1'b1;
    @(posedge clk);
    #1;
    rx_bus.rx_valid_i = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send(8'hA5);
    send(a);
    send(d);
    send(c);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] junk [3];
    junk[0] = 8'h00; junk[1] = 8'hFF; junk[2] = 8'h3C;
    rx_bus.rx_data_i  = 8'h00;
    rx_bus.rx_valid_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_regs",     regs,     32'h4433_2211);
    check("rst_wr",       wr,       32'd0);
    check("rst_err",      err,      32'd0);
    check("rst_busy",     busy,     32'd0);
    check("rst_wr_addr",  wr_addr,  32'd0);
    check("rst_err_code", err_code, 32'd0);
    rst = 1'b0;
    idle_cycle();

    // Valid write to reg 2
    send(8'hA5);
    check("sync_busy",  busy,  32'd1);
    check("sync_state", state, 32'd1);
    send(8'h02);
    send(8'h5A);
    send(8'h58);
    check("w2_wr",      wr,      32'd1);
    check("w2_wr_addr", wr_addr, 32'd2);
    check("w2_regs",    regs,    32'h445A_2211);
    check("w2_busy",    busy,    32'd0);
    check("w2_err",     err,     32'd0);
    idle_cycle();
    check("w2_wr_pulse", wr, 32'd0);

    // Checksum error
    send_frame(8'h01, 8'h10, 8'h00);
    check("ck_err",  err,      32'd1);
    check("ck_code", err_code, 32'd1);
    check("ck_wr",   wr,       32'd0);
    check("ck_regs", regs,     32'h445A_2211);
    idle_cycle();
    check("ck_err_pulse", err, 32'd0);

    // Bad address (checksum good)
    send_frame(8'h07, 8'h00, 8'h07);
    check("ad_err",  err,      32'd1);
    check("ad_code", err_code, 32'd2);
    check("ad_wr",   wr,       32'd0);
    check("ad_regs", regs,     32'h445A_2211);
    idle_cycle();

    // Timeout: 16 cycles after the 03 strobe
    send(8'hA5);
    send(8'h03);
    repeat (15) idle_cycle();
    check("to_early_err",  err,  32'd0);
    check("to_early_busy", busy, 32'd1);
    idle_cycle();
    check("to_err",  err,      32'd1);
    check("to_code", err_code, 32'd3);
    check("to_busy", busy,     32'd0);
    idle_cycle();
    check("to_err_pulse", err, 32'd0);
    send_frame(8'h00, 8'hFF, 8'hFF);
    check("w0_wr",      wr,      32'd1);
    check("w0_wr_addr", wr_addr, 32'd0);
    check("w0_regs",    regs,    32'h445A_22FF);
    idle_cycle();

    // Junk ignored, then mid-frame A5 used as data
    for (int i = 0; i < 3; i++) begin
      send(junk[i]);
      check("junk_err",  err,  32'd0);
      check("junk_busy", busy, 32'd0);
    end
    send_frame(8'h01, 8'hA5, 8'hA4);
    check("w1_wr",   wr,   32'd1);
    check("w1_regs", regs, 32'h445A_A5FF);
    idle_cycle();

    // Back-to-back strobes with a byte in the expiry cycle
    send(8'hA5);
    send(8'h03);
    repeat (15) idle_cycle();
    check("exp_pre_err", err, 32'd0);
    send(8'h81);
    check("exp_err",  err,  32'd0);
    check("exp_busy", busy, 32'd1);
    send(8'h82);
    check("w3_wr",   wr,   32'd1);
    check("w3_err",  err,  32'd0);
    check("w3_regs", regs, 32'h815A_A5FF);
    idle_cycle();

    // Reset in the middle of a frame
    send(8'hA5);
    send(8'h00);
    rst = 1'b1;
    #1;
    check("mr_busy",  busy,  32'd0);
    check("mr_state", state, 32'd0);
    check("mr_regs",  regs,  32'h4433_2211);
    idle_cycle();
    rst = 1'b0;
    idle_cycle();
    send(8'h00);
    check("mr_after_busy", busy, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command-frame controller placed downstream of the RS-232 receiver. It consumes the received byte stream (byte plus end-of-reception strobe), parses fixed 4-byte write frames, checks them and commits the data into a 4-entry × 8-bit configuration register file that drives the rest of the design. Malformed frames, bad addresses and stalled frames are rejected and reported with a one-cycle error strobe and code.

## Interface
- `TIMEOUT`, default 1_000_000: inter-byte timeout in clk cycles while a frame is in progress; must be ≥ 2.
- `REG_INIT`, default 32'h0000_0000: reset value of the register file; byte k = `REG_INIT[8k+7:8k]`.

Ports:
- `clk_i`  in  1: single clock, all logic rising-edge.
- `rst_i`  in  1: reset, asynchronous and active-high.
- `rx_data_i`  in  8: received byte, valid when `rx_valid_i` = 1.
- `rx_valid_i`  in  1: one-cycle strobe per received byte (receiver end-of-reception).
- `regs_o`  out  32: register file; reg k at `[8k+7:8k]`, registered.
- `wr_o`  out  1: one-cycle strobe, a register was written.
- `wr_addr_o`  out  2: index of the register written; held until the next write.
- `err_o`  out  1: one-cycle strobe, frame rejected.
- `err_code_o`  out  2: 1 = checksum, 2 = bad address, 3 = timeout; held until the next error.
- `busy_o`  out  1: 1 while a frame is in progress (state ≠ IDLE).

## Operation
- Frame: SYNC (8'hA5), ADDR, DATA, CHK. A frame is valid when CHK = ADDR ^ DATA and ADDR ≤ 3.
- States: IDLE, GET_ADDR, GET_DATA, GET_CHK. Transitions occur only on `rx_valid_i`, except for timeout.
  - IDLE: byte = A5 → GET_ADDR. Any other byte is ignored silently, with no error.
  - GET_ADDR: latch ADDR (full 8 bits) → GET_DATA.
  - GET_DATA: latch DATA → GET_CHK.
  - GET_CHK: evaluate and return to IDLE in all cases.
    - Checksum wrong → error, code 1. The checksum is checked first.
    - Else ADDR > 3 → error, code 2.
    - Else write `regs_o` byte ADDR[1:0] ← DATA, and pulse `wr_o`.
- An A5 byte received mid-frame is treated as ordinary data. There is no resynchronisation.
- Timeout counter:
  - Cleared on every accepted byte and held at 0 in IDLE.
  - Increments each cycle in non-IDLE states with no `rx_valid_i`.
  - When the count reaches `TIMEOUT-1` and `rx_valid_i` = 0: return to IDLE, pulse `err_o`, code 3. Partial ADDR/DATA are discarded.
- A byte arriving in the expiry cycle wins: it is accepted and the counter is reloaded.
- After any error the next A5 starts a fresh frame. The byte in the error cycle is not re-examined.
- Reset (any time, including mid-frame):
  - State → IDLE; counter → 0.
  - `regs_o` = `REG_INIT`; `wr_o` = 0, `wr_addr_o` = 0, `err_o` = 0, `err_code_o` = 0, `busy_o` = 0.
- Counter width is $clog2(TIMEOUT). There is no wrap-around, because expiry forces IDLE.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Byte accepted on the cycle where `rx_valid_i` = 1 (edge n). The state update is visible at n+1.
- CHK strobe at edge n:
  - `regs_o`, `wr_o`, `wr_addr_o` (or `err_o`, `err_code_o`) update at n+1.
  - `wr_o`/`err_o` are high for exactly that one cycle.
- `busy_o` rises the cycle after SYNC is accepted and falls the cycle after CHK or timeout.
- Timeout error is asserted exactly `TIMEOUT` cycles after the last accepted byte's strobe.
- Back-to-back strobes on consecutive cycles are legal. Each is consumed, so there is no input back-pressure.
- `wr_o` and `err_o` are never high in the same cycle.

## Test plan
- Reset with `REG_INIT`=32'h44332211: `regs_o`=32'h44332211, all strobes 0, `busy_o`=0; assert `rst_i` mid-frame → IDLE, `regs_o` restored.
- Frame A5,02,5A,58 → one cycle after CHK, `wr_o`=1, `wr_addr_o`=2, `regs_o[23:16]`=8'h5A, other bytes unchanged, `busy_o`=0.
- Frame A5,01,10,00 → `err_o`=1, `err_code_o`=1, no write. Then frame A5,07,00,07 → `err_code_o`=2, no write.
- `TIMEOUT`=16, send A5,03 then stop → `err_o` exactly 16 cycles after the 03 strobe, code 3. Then A5,00,FF,FF → reg0=8'hFF.
- Junk 00,FF,3C before A5,01,A5,A4 → junk ignored with no `err_o`; reg1=8'hA5 (mid-frame A5 treated as data).
- Strobes on consecutive cycles for A5,03,81,82, plus a byte coincident with the expiry cycle → frame accepted, reg3=8'h81, no timeout error.
